// File: rtl/resp_fanin_rr_bridge_pkg.sv
// ============================================================================
// resp_fanin_rr_bridge_pkg : shared XBAR bridge types and round-robin helper
// Rev 1.0
// ============================================================================
`default_nettype none

package resp_fanin_rr_bridge_pkg;

  localparam int unsigned MAX_PORTS = 32;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

  typedef logic [MAX_PORTS-1:0] rr_req_t;

  // First requester at or after ptr, wrapping within n; returns ptr if none.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input rr_req_t     req,
                                          input int unsigned n);
    int unsigned grant;
    int unsigned idx;
    logic        found;
    grant = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[IDX_W-1:0]]) begin
          grant = idx;
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/resp_fanin_rr_bridge_if.sv
// ============================================================================
// resp_fanin_rr_bridge_if : per-port response inputs and merged response output
// Rev 1.0
// ============================================================================
`default_nettype none

interface resp_fanin_rr_bridge_if #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 6
);
  localparam int SRC_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS*DATA_WIDTH-1:0] data_r_rdata_i;
  logic [N_PORTS-1:0]            data_r_valid_i;
  logic [N_PORTS-1:0]            data_r_opc_i;
  logic [N_PORTS*AUX_WIDTH-1:0]  data_r_aux_i;
  logic                          overflow_clr_i;

  logic [DATA_WIDTH-1:0]         data_r_rdata_o;
  logic                          data_r_valid_o;
  logic                          data_r_opc_o;
  logic [AUX_WIDTH-1:0]          data_r_aux_o;
  logic [SRC_W-1:0]              data_r_src_o;
  logic [N_PORTS-1:0]            fifo_full_o;
  logic [N_PORTS-1:0]            overflow_o;

  modport slave (
    input  data_r_rdata_i, data_r_valid_i, data_r_opc_i, data_r_aux_i, overflow_clr_i,
    output data_r_rdata_o, data_r_valid_o, data_r_opc_o, data_r_aux_o, data_r_src_o,
           fifo_full_o, overflow_o
  );

  modport master (
    output data_r_rdata_i, data_r_valid_i, data_r_opc_i, data_r_aux_i, overflow_clr_i,
    input  data_r_rdata_o, data_r_valid_o, data_r_opc_o, data_r_aux_o, data_r_src_o,
           fifo_full_o, overflow_o
  );

endinterface

`default_nettype wire

// File: rtl/resp_fanin_rr_bridge_fifo.sv
// ============================================================================
// resp_fifo : single-clock FIFO; a push into a full FIFO is kept only if popped
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           din_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           dout_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/resp_fanin_rr_bridge.sv
// ============================================================================
// resp_fanin_rr_bridge : N-way buffered response fan-in with round-robin drain
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_fanin_rr_bridge
  import resp_fanin_rr_bridge_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 6,
  parameter int FIFO_DEPTH = 2
) (
  input wire logic               clk,
  input wire logic               rst,
  resp_fanin_rr_bridge_if.slave  bus
);

  localparam int SRC_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PAY_W = DATA_WIDTH + AUX_WIDTH + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PAY_W-1:0]   wr_pay [N_PORTS];
  logic [PAY_W-1:0]   head   [N_PORTS];
  logic [CNT_W-1:0]   count  [N_PORTS];
  logic [N_PORTS-1:0] full, empty, pop, drop;

  logic [SRC_W-1:0]      grant;
  logic                  any_req;
  rr_req_t               req_pad;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  opc_q,   opc_d;
  logic [AUX_WIDTH-1:0]  aux_q,   aux_d;
  logic [SRC_W-1:0]      src_q,   src_d;
  logic [SRC_W-1:0]      ptr_q,   ptr_d;
  logic [N_PORTS-1:0]    ovf_q,   ovf_d;

  generate
    for (genvar k = 0; k < N_PORTS; k++) begin : g_port
      assign wr_pay[k] = {bus.data_r_opc_i[k],
                          bus.data_r_aux_i[k*AUX_WIDTH +: AUX_WIDTH],
                          bus.data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]};

      resp_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.data_r_valid_i[k]),
        .din_i   (wr_pay[k]),
        .pop_i   (pop[k]),
        .dout_o  (head[k]),
        .full_o  (full[k]),
        .empty_o (empty[k]),
        .count_o (count[k])
      );

      // A push into a full FIFO survives only when that FIFO is drained this edge.
      assign drop[k] = bus.data_r_valid_i[k] && (count[k] == CNT_W'(FIFO_DEPTH)) && !pop[k];
    end
  endgenerate

  always_comb begin
    req_pad                = '0;
    req_pad[N_PORTS-1:0]   = ~empty;
    any_req                = |(~empty);
    grant                  = SRC_W'(rr_next(32'(ptr_q), req_pad, N_PORTS));
    pop                    = '0;
    ptr_d                  = ptr_q;
    valid_d                = any_req;
    rdata_d                = rdata_q;
    opc_d                  = opc_q;
    aux_d                  = aux_q;
    src_d                  = src_q;
    if (any_req) begin
      pop[grant]               = 1'b1;
      ptr_d                    = (32'(grant) == N_PORTS - 1) ? '0 : grant + 1'b1;
      {opc_d, aux_d, rdata_d}  = head[grant];
      src_d                    = grant;
    end
    // A drop on the clearing edge still wins.
    ovf_d = (bus.overflow_clr_i ? '0 : ovf_q) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
      aux_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      opc_q   <= opc_d;
      aux_q   <= aux_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.data_r_valid_o = valid_q;
  assign bus.data_r_rdata_o = rdata_q;
  assign bus.data_r_opc_o   = opc_q;
  assign bus.data_r_aux_o   = aux_q;
  assign bus.data_r_src_o   = src_q;
  assign bus.fifo_full_o    = full;
  assign bus.overflow_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_resp_fanin_rr_bridge.sv
// ============================================================================
// tb_resp_fanin_rr_bridge : directed scoreboard bench, 4 ports, depth-2 FIFOs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_resp_fanin_rr_bridge;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int D  = 2;

  typedef struct packed {
    logic [1:0]    src;
    logic          opc;
    logic [AW-1:0] aux;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resp_fanin_rr_bridge_if #(.N_PORTS(N), .DATA_WIDTH(DW), .AUX_WIDTH(AW)) bus ();

  resp_fanin_rr_bridge #(
    .N_PORTS(N), .DATA_WIDTH(DW), .AUX_WIDTH(AW), .FIFO_DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic rsp_t mk(input int p, input int n);
    rsp_t r;
    r.src   = 2'(p);
    r.opc   = n[0];
    r.aux   = 6'(p * 8 + n);
    r.rdata = 32'hC0DE_0000 | 32'(p << 8) | 32'(n);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.data_r_valid_i = '0;
    bus.overflow_clr_i = 1'b0;
  endtask

  task automatic push(input rsp_t r);
    int p;
    p = int'(r.src);
    bus.data_r_valid_i[p]           = 1'b1;
    bus.data_r_opc_i[p]             = r.opc;
    bus.data_r_aux_i[p*AW +: AW]    = r.aux;
    bus.data_r_rdata_i[p*DW +: DW]  = r.rdata;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.data_r_valid_o), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.data_r_rdata_o), 64'd0);
    chk({tag, "_opc"},   64'(bus.data_r_opc_o),   64'd0);
    chk({tag, "_aux"},   64'(bus.data_r_aux_o),   64'd0);
    chk({tag, "_src"},   64'(bus.data_r_src_o),   64'd0);
    chk({tag, "_full"},  64'(bus.fifo_full_o),    64'd0);
    chk({tag, "_ovf"},   64'(bus.overflow_o),     64'd0);
  endtask

  // Four-port collision: expects back-to-back outputs in the given source order.
  task automatic collision(input string tag, input int n, input int first);
    for (int p = 0; p < N; p++) push(mk(p, n));
    for (int i = 0; i < N; i++) exp_q.push_back(mk((first + i) % N, n));
    nxt();
    chk({tag, "_lat"}, 64'(bus.data_r_valid_o), 64'd0);
    for (int i = 0; i < N; i++) begin
      nxt();
      chk({tag, "_valid"}, 64'(bus.data_r_valid_o), 64'd1);
      chk({tag, "_src"},   64'(bus.data_r_src_o),   64'((first + i) % N));
    end
    nxt();
    chk({tag, "_idle"}, 64'(bus.data_r_valid_o), 64'd0);
  endtask

  initial begin : monitor
    rsp_t got, e;
    forever begin
      @(negedge clk);
      if (!rst && bus.data_r_valid_o) begin
        got = {bus.data_r_src_o, bus.data_r_opc_o, bus.data_r_aux_o, bus.data_r_rdata_o};
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got 0x%0h expected none at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rsp_t r;
    rst                = 1'b1;
    bus.data_r_rdata_i = '0;
    bus.data_r_opc_i   = '0;
    bus.data_r_aux_i   = '0;
    idle();
    repeat (2) @(negedge clk);
    chk_zero("por");
    rst = 1'b0;

    collision("colA", 0, 0);
    collision("colB", 1, 0);

    // Single response on port 2: two-edge latency, then outputs hold
    r = '{src: 2'd2, opc: 1'b1, aux: 6'h15, rdata: 32'hDEADBEEF};
    exp_q.push_back(r);
    push(r);
    nxt(); chk("single_lat", 64'(bus.data_r_valid_o), 64'd0);
    nxt(); chk("single_valid", 64'(bus.data_r_valid_o), 64'd1);
           chk("single_src",   64'(bus.data_r_src_o),   64'd2);
    nxt(); chk("single_pulse", 64'(bus.data_r_valid_o), 64'd0);
           chk("single_hold",  64'(bus.data_r_rdata_o), 64'hDEADBEEF);
           chk("single_hold_aux", 64'(bus.data_r_aux_o), 64'h15);

    collision("colC", 2, 3);

    // Reset with three responses buffered; none may reappear
    push(mk(0, 3)); push(mk(1, 3)); push(mk(2, 3));
    nxt();
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) nxt();
    chk("rst_stale", 64'(bus.data_r_valid_o), 64'd0);

    // Fairness/overflow on port 0; ptr restarts at 0 after reset
    exp_q.push_back(mk(0, 4)); exp_q.push_back(mk(1, 4)); exp_q.push_back(mk(2, 4));
    exp_q.push_back(mk(3, 4)); exp_q.push_back(mk(0, 5)); exp_q.push_back(mk(0, 6));
    exp_q.push_back(mk(0, 9));
    for (int p = 0; p < N; p++) push(mk(p, 4));
    nxt(); push(mk(0, 5));
    nxt(); push(mk(0, 6));
           chk("fair_src0", 64'(bus.data_r_src_o), 64'd0);
    nxt(); push(mk(0, 7));
    nxt(); push(mk(0, 8));
           chk("fair_ovf_set", 64'(bus.overflow_o),  64'b0001);
           chk("fair_full",    64'(bus.fifo_full_o), 64'b0001);
    nxt(); push(mk(0, 9));
           chk("fair_src3", 64'(bus.data_r_src_o), 64'd3);
    nxt(); chk("fair_full_pp", 64'(bus.fifo_full_o), 64'b0001);
    nxt();
    nxt();
    nxt(); chk("fair_ovf_sticky", 64'(bus.overflow_o), 64'b0001);
           chk("fair_drained",    64'(bus.fifo_full_o), 64'd0);
    bus.overflow_clr_i = 1'b1;
    nxt(); chk("fair_ovf_clr", 64'(bus.overflow_o), 64'd0);

    // Port 1 full and winning while a new push arrives (ptr = 1 here)
    exp_q.push_back(mk(2, 10)); exp_q.push_back(mk(3, 10));
    exp_q.push_back(mk(1, 10)); exp_q.push_back(mk(1, 11)); exp_q.push_back(mk(1, 12));
    push(mk(3, 10)); push(mk(2, 10));
    nxt(); push(mk(1, 10));
    nxt(); push(mk(1, 11));
    nxt(); push(mk(1, 12));
           chk("fp_full", 64'(bus.fifo_full_o), 64'b0010);
    nxt(); chk("fp_full_kept", 64'(bus.fifo_full_o), 64'b0010);
           chk("fp_no_ovf",    64'(bus.overflow_o),  64'd0);
    repeat (3) nxt();
    chk("fp_idle", 64'(bus.data_r_valid_o), 64'd0);

    // Clear racing a new drop on port 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(0, 20)); exp_q.push_back(mk(1, 20)); exp_q.push_back(mk(2, 20));
    exp_q.push_back(mk(0, 21)); exp_q.push_back(mk(2, 21)); exp_q.push_back(mk(0, 22));
    exp_q.push_back(mk(2, 23));
    push(mk(0, 20)); push(mk(1, 20)); push(mk(2, 20));
    nxt(); push(mk(0, 21)); push(mk(2, 21));
    nxt(); push(mk(0, 22)); push(mk(2, 22));
    nxt(); chk("race_ovf2", 64'(bus.overflow_o), 64'b0100);
           push(mk(0, 23)); push(mk(2, 23));
    nxt(); chk("race_ovf02", 64'(bus.overflow_o), 64'b0101);
           push(mk(2, 24)); bus.overflow_clr_i = 1'b1;
    nxt(); chk("race_clr_vs_set", 64'(bus.overflow_o), 64'b0100);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) nxt();
    repeat (2) nxt();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d responses pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/resp_fanin_rr_bridge.md
# resp_fanin_rr_bridge

N-way response fan-in for the XBAR bridge: merges read/write responses from `N_PORTS` upstream slaves onto one downstream response channel. Unlike the 2:1 combinational merge, simultaneous responses are legal. Each port buffers its responses in its own FIFO, and a round-robin arbiter drains one response per cycle into a registered output stage. Buffer overflow is flagged per port, never silently merged.

## Interface
- `N_PORTS`, 2, number of upstream response sources (≥1)
- `DATA_WIDTH`, 32, response data width
- `AUX_WIDTH`, 6, auxiliary/ID field width
- `FIFO_DEPTH`, 2, entries per port FIFO (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `data_r_rdata_i`  in  N_PORTS×DATA_WIDTH  per-port response data
- `data_r_valid_i`  in  N_PORTS  per-port response valid (no back-pressure; a valid is a push)
- `data_r_opc_i`  in  N_PORTS  per-port opcode/error bit
- `data_r_aux_i`  in  N_PORTS×AUX_WIDTH  per-port aux field
- `data_r_rdata_o`  out  DATA_WIDTH  merged data
- `data_r_valid_o`  out  1  merged valid, one cycle per response
- `data_r_opc_o`  out  1  merged opcode
- `data_r_aux_o`  out  AUX_WIDTH  merged aux
- `data_r_src_o`  out  $clog2(N_PORTS) (min 1)  index of the port that sourced the current output
- `fifo_full_o`  out  N_PORTS  port FIFO full (combinational from count)
- `overflow_o`  out  N_PORTS  sticky: a push was dropped on this port
- `overflow_clr_i`  in  1  synchronous clear of all `overflow_o` bits

## Operation
- Push: `data_r_valid_i[k]=1` at a rising edge writes {rdata, opc, aux} into FIFO k.
- A push is accepted if count_k < FIFO_DEPTH, or if FIFO k is popped on the same edge.
- Otherwise the push is dropped and `overflow_o[k]` is set on that edge.
- Arbitration: round-robin over non-empty FIFOs, starting the search at priority pointer `ptr`.
  - The winner g is popped and its head is loaded into the output register at the same edge.
  - `ptr` then becomes (g+1) mod N_PORTS.
  - With no request, `ptr` is unchanged.
- Output register: `data_r_valid_o` is 1 for exactly the cycle after a pop, else 0.
- When `data_r_valid_o=0`, the data/opc/aux/src outputs hold their last values.
- Ordering: per-port order is preserved. There is no ordering guarantee across ports.
- `overflow_clr_i=1` clears all overflow bits. A new overflow on the same edge wins (bit stays set).
- `N_PORTS=1`: the arbiter degenerates, `ptr` stays 0 and `data_r_src_o` stays 0.

## Timing
- Reset (async assert) state:
  - all FIFOs empty; `ptr`=0; `overflow_o`=0
  - `data_r_valid_o`=0; `data_r_rdata_o`=0; `data_r_opc_o`=0; `data_r_aux_o`=0; `data_r_src_o`=0
  - `fifo_full_o`=0
- Reset is released synchronously to `clk` by the integrator. Asserting reset mid-operation discards all buffered responses.
- Latency: valid at edge e into an empty FIFO with no contention → `data_r_valid_o` high in the cycle following edge e+1, i.e. 2 edges.
- Throughput: 1 response/cycle aggregate. Each port is guaranteed service within N_PORTS arbitration cycles.
- Full FIFO with a same-edge pop and push: the push is accepted, count is unchanged, no overflow.
- Full FIFO, push, no pop: data dropped, count unchanged, `overflow_o[k]` set.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Structure
- Sub-module `resp_fifo` (params WIDTH, DEPTH): single-clock FIFO with push/pop/full/empty/count and async active-high reset. It is instantiated N_PORTS times in a generate loop.
- The response payload is a packed {opc, aux, rdata} vector of width DATA_WIDTH+AUX_WIDTH+1. It is built locally because its width is parametric.
- The shared XBAR bridge package holds the `rr_next(ptr, req, n)` round-robin helper function, which is reused by other bridge arbiters.

## Test plan
- Single response: N=4, port 2 pushes rdata=0xDEADBEEF, aux=0x15, opc=1 → two edges later valid_o=1 for one cycle with the same fields and src_o=2.
- Full collision: ports 0–3 all push in one cycle, ptr=0 → outputs emerge on 4 consecutive cycles from src 0,1,2,3; ptr ends at 0.
- Fairness: port 0 pushes every cycle while port 3 pushes once → port 3 is served within 4 output cycles. Port 0 overflows with FIFO_DEPTH=2: overflow_o[0]=1 and it stays set until overflow_clr_i is asserted.
- Full plus simultaneous pop: FIFO 1 full and winning arbitration, new push → accepted, fifo_full_o[1] stays 1, overflow_o[1] stays 0, per-port order intact.
- Reset mid-burst: assert rst with 3 entries buffered → all outputs 0 immediately. After release, no stale response appears and ptr=0.
- Clear vs set race: overflow_clr_i=1 on the same edge as a dropped push on port 2 → overflow_o[2]=1 and all other bits are cleared.
